// File: rtl/wram_stream.sv
// Multi-slot message-schedule word RAM, filled and drained as LANES-word beats.
module wram_stream #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned WORDS      = 64,
    parameter int unsigned SLOTS      = 8,
    parameter int unsigned LANES      = 16,
    localparam int unsigned SLOT_W    = (SLOTS > 1) ? $clog2(SLOTS) : 1,
    localparam int unsigned BW        = DATA_WIDTH * LANES
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_wr_valid,
    input  logic [SLOT_W-1:0] i_wr_slot,
    input  logic [BW-1:0]     i_wr_data,
    output logic              o_wr_ready,
    input  logic              i_rd_req,
    input  logic [SLOT_W-1:0] i_rd_slot,
    input  logic              i_rd_consume,
    output logic              o_rd_ready,
    output logic [BW-1:0]     o_rd_data,
    output logic              o_rd_valid,
    output logic              o_rd_last,
    input  logic              i_rd_ready,
    output logic [SLOTS-1:0]  o_slot_full
);

    localparam int unsigned BEATS  = WORDS / LANES;
    localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned DEPTH  = SLOTS * BEATS;
    localparam int unsigned ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic {W_IDLE = 1'b0, W_FILL = 1'b1} wstate_e;
    typedef enum logic {R_IDLE = 1'b0, R_STREAM = 1'b1} rstate_e;

    // One storage row per (slot, beat); never reset.
    logic [BW-1:0] mem_q [DEPTH];

    wstate_e            wstate_q, wstate_d;
    logic [BEAT_W-1:0]  wcnt_q, wcnt_d;
    logic [SLOT_W-1:0]  wslot_q, wslot_d;
    rstate_e            rstate_q, rstate_d;
    logic [BEAT_W-1:0]  rcnt_q, rcnt_d;
    logic [SLOT_W-1:0]  rslot_q, rslot_d;
    logic               rcons_q, rcons_d;
    logic [BW-1:0]      rd_data_q, rd_data_d;
    logic               rd_valid_q, rd_valid_d;
    logic               rd_last_q, rd_last_d;
    logic [SLOTS-1:0]   slot_full_q, slot_full_d;

    logic               wr_fire_c;
    logic [SLOT_W-1:0]  wr_slot_c;
    logic [BEAT_W-1:0]  wr_beat_c;
    logic [SLOTS-1:0]   full_set_c;
    logic [SLOTS-1:0]   full_clr_c;
    logic               rd_fire_c;
    logic [BEAT_W-1:0]  rnext_c;

    function automatic logic [ADDR_W-1:0] addr_of(input logic [SLOT_W-1:0] s,
                                                   input logic [BEAT_W-1:0] b);
        return ADDR_W'(s) * ADDR_W'(BEATS) + ADDR_W'(b);
    endfunction

    // Write FSM: first beat picks the slot, last beat marks it full.
    always_comb begin
        wstate_d   = wstate_q;
        wcnt_d     = wcnt_q;
        wslot_d    = wslot_q;
        full_set_c = '0;
        wr_slot_c  = (wstate_q == W_IDLE) ? i_wr_slot : wslot_q;
        wr_beat_c  = (wstate_q == W_IDLE) ? '0 : wcnt_q;
        o_wr_ready = (wstate_q == W_IDLE) ? !slot_full_q[i_wr_slot] : 1'b1;
        wr_fire_c  = i_wr_valid && o_wr_ready;
        if (wr_fire_c) begin
            if (wr_beat_c == BEAT_W'(BEATS - 1)) begin
                wstate_d              = W_IDLE;
                wcnt_d                = '0;
                full_set_c[wr_slot_c] = 1'b1;
            end else begin
                wstate_d = W_FILL;
                wcnt_d   = wr_beat_c + BEAT_W'(1);
                wslot_d  = wr_slot_c;
            end
        end
    end

    // Read FSM: beat pipeline with no bubble between accepted beats.
    always_comb begin
        rstate_d   = rstate_q;
        rcnt_d     = rcnt_q;
        rslot_d    = rslot_q;
        rcons_d    = rcons_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = rd_valid_q;
        rd_last_d  = rd_last_q;
        full_clr_c = '0;
        rnext_c    = rcnt_q + BEAT_W'(1);
        o_rd_ready = (rstate_q == R_IDLE) && slot_full_q[i_rd_slot];
        rd_fire_c  = i_rd_req && o_rd_ready;
        case (rstate_q)
            R_IDLE: begin
                if (rd_fire_c) begin
                    rstate_d   = R_STREAM;
                    rslot_d    = i_rd_slot;
                    rcons_d    = i_rd_consume;
                    rcnt_d     = '0;
                    rd_data_d  = mem_q[addr_of(i_rd_slot, '0)];
                    rd_valid_d = 1'b1;
                    rd_last_d  = (BEATS == 1);
                end
            end
            default: begin
                if (rd_valid_q && i_rd_ready) begin
                    if (rd_last_q) begin
                        rstate_d   = R_IDLE;
                        rcnt_d     = '0;
                        rd_valid_d = 1'b0;
                        rd_last_d  = 1'b0;
                        if (rcons_q) begin
                            full_clr_c[rslot_q] = 1'b1;
                        end
                    end else begin
                        rcnt_d    = rnext_c;
                        rd_data_d = mem_q[addr_of(rslot_q, rnext_c)];
                        rd_last_d = (rnext_c == BEAT_W'(BEATS - 1));
                    end
                end
            end
        endcase
    end

    // Set and clear never target the same slot, so their order is irrelevant.
    always_comb begin
        slot_full_d = (slot_full_q & ~full_clr_c) | full_set_c;
    end

    // Control and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wstate_q    <= W_IDLE;
            wcnt_q      <= '0;
            wslot_q     <= '0;
            rstate_q    <= R_IDLE;
            rcnt_q      <= '0;
            rslot_q     <= '0;
            rcons_q     <= 1'b0;
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
            rd_last_q   <= 1'b0;
            slot_full_q <= '0;
        end else begin
            wstate_q    <= wstate_d;
            wcnt_q      <= wcnt_d;
            wslot_q     <= wslot_d;
            rstate_q    <= rstate_d;
            rcnt_q      <= rcnt_d;
            rslot_q     <= rslot_d;
            rcons_q     <= rcons_d;
            rd_data_q   <= rd_data_d;
            rd_valid_q  <= rd_valid_d;
            rd_last_q   <= rd_last_d;
            slot_full_q <= slot_full_d;
        end
    end

    // Beat storage write port.
    always_ff @(posedge clk) begin
        if (wr_fire_c) begin
            mem_q[addr_of(wr_slot_c, wr_beat_c)] <= i_wr_data;
        end
    end

    assign o_rd_data   = rd_data_q;
    assign o_rd_valid  = rd_valid_q;
    assign o_rd_last   = rd_last_q;
    assign o_slot_full = slot_full_q;

endmodule

// File: doc/wram_stream.md
# wram_stream

Parametrised successor to the single-shot message-schedule word RAM. Holds SLOTS message-schedule blocks of WORDS words each. Blocks are filled and drained as LANES-word beats over valid/ready handshakes instead of one full-width copy. Per-slot full flags let the padding/expansion front end and the compression rounds run concurrently on different slots. The block sits between the W-expansion stage and the SHA-256 round engines.

## Interface
- DATA_WIDTH, 32, bits per word
- WORDS, 64, words per slot (block)
- SLOTS, 8, number of independent block slots
- LANES, 16, words per beat; WORDS must be a multiple of LANES; BEATS = WORDS/LANES
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous, active-low
- i_wr_valid  in  1  write beat valid
- i_wr_slot  in  $clog2(SLOTS)  target slot; sampled on first beat only
- i_wr_data  in  DATA_WIDTH*LANES  beat data; word j at [j*DATA_WIDTH +: DATA_WIDTH]
- o_wr_ready  out  1  write beat accepted when high with i_wr_valid
- i_rd_req  in  1  read request valid
- i_rd_slot  in  $clog2(SLOTS)  slot to drain
- i_rd_consume  in  1  sampled with request; free the slot after its last beat
- o_rd_ready  out  1  read request accepted when high with i_rd_req
- o_rd_data  out  DATA_WIDTH*LANES  read beat, registered
- o_rd_valid  out  1  o_rd_data valid
- o_rd_last  out  1  marks beat BEATS-1
- i_rd_ready  in  1  downstream accepts read beat
- o_slot_full  out  SLOTS  bit s = slot s holds a complete block

## Operation
- Write FSM W_IDLE / W_FILL with beat counter wcnt (0..BEATS-1) and latched wslot.
- W_IDLE: o_wr_ready = !o_slot_full[i_wr_slot] (combinational). On handshake: beat 0 goes to words 0..LANES-1 of i_wr_slot. wslot latched; wcnt=1. Go to W_FILL, or directly to full if BEATS==1.
- W_FILL: o_wr_ready=1; i_wr_slot ignored. Beat k writes words k*LANES..k*LANES+LANES-1 of wslot. On beat BEATS-1: o_slot_full[wslot] set at that edge; return to W_IDLE.
- i_wr_valid low mid-fill stalls; the FSM holds state with no timeout.
- Read FSM R_IDLE / R_STREAM with beat counter rcnt and latched rslot and consume flag.
- R_IDLE: o_rd_ready = o_slot_full[i_rd_slot]. On handshake: load beat 0 into o_rd_data, set o_rd_valid, go to R_STREAM.
- R_STREAM: o_rd_ready=0. On o_rd_valid && i_rd_ready: load the next beat the same edge (no bubble). o_rd_data, o_rd_valid and o_rd_last hold while i_rd_ready is low.
- Handshake of the beat with o_rd_last=1: o_rd_valid drops to 0 and the FSM goes to R_IDLE. If consume was latched, o_slot_full[rslot] clears at that edge. A full slot without consume stays full and may be re-read.
- A slot is never written while full and never read while not full, so same-slot write/read conflicts cannot occur.
- Same edge: consume-clear of slot s and a W_IDLE write attempt to s. The write sees the pre-edge flag (not ready) and succeeds the next cycle.
- Write and read paths on different slots are fully concurrent.
- Storage array is not reset. Contents of a freed slot are stale until rewritten.

## Timing
- Reset values: o_rd_data=0, o_rd_valid=0, o_rd_last=0, o_slot_full=0; both FSMs idle; counters 0.
- o_wr_ready and o_rd_ready are combinational from state and flags; all other outputs are registered.
- Fill latency: the last write beat handshakes at cycle T; o_slot_full is visible at T+1. A read request is accepted at T+1 at the earliest.
- Read latency: request handshake at T gives beat 0 valid at T+1. With i_rd_ready held high, beats stream on consecutive cycles and the last beat is at T+BEATS.
- Reset assertion mid-fill or mid-drain: both FSMs abort and all flags clear. A partially written slot is never flagged full.

## Test plan
- Reset then fill slot 3 with words 0x00000000..0x0000003F (4 beats, LANES=16). o_slot_full=8'h08 one cycle after beat 3.
- Read slot 3, consume=1, i_rd_ready=1. Beat 0 word 0 = 0x00000000 at T+1, 4 consecutive beats, o_rd_last on beat 3. o_slot_full=8'h00 after the last handshake.
- Same as the previous case with i_rd_ready toggling 1,0,0,1,...: o_rd_data stable while stalled, exactly 4 handshakes, no duplicated or dropped words.
- Attempt to write full slot 3 (consume=0 read done earlier). o_wr_ready=0; slot contents unchanged on re-read.
- Fill slot 1 while draining slot 3 concurrently; read request on empty slot 5: o_rd_ready=0 until slot 5 is filled.
- Assert rst_n low after 2 write beats to slot 2: o_slot_full=0, a read request for slot 2 is refused, and a fresh fill succeeds.
